// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Wide enough to hold the largest read latency (4)
  localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       valid
);

  // A lone requester wins outright; on a tie the port not served last time wins
  always_comb begin
    valid = |req;
    win   = PORT_CPU;
    case (req)
      2'b01:   win = PORT_CPU;
      2'b10:   win = PORT_AUX;
      2'b11:   win = ~last;
      default: win = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for a single-port memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic [1:0] arb_req;
  logic       arb_win;
  logic       arb_valid;

  assign arb_req = {p1_read | p1_write, p0_read | p0_write};

  rr_arb2 u_rr_arb2 (
    .req   (arb_req),
    .last  (last_q),
    .win   (arb_win),
    .valid (arb_valid)
  );

  // Sequencer: the memory strobes are loaded on entry to ACCESS and zeroed on
  // every other transition, so they double as the latched request fields
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d       = arb_win;
          mem_en_d    = 1'b1;
          mem_we_d    = (arb_win == PORT_AUX) ? p1_write : p0_write;
          mem_addr_d  = (arb_win == PORT_AUX) ? p1_addr : p0_addr;
          mem_wdata_d = (arb_win == PORT_AUX) ? p1_wdata : p0_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Count of 1 marks the cycle in which the memory presents read data
        if (cnt_q == CNT_W'(1)) begin
          if (win_q == PORT_AUX) p1_rdata_d = mem_rdata;
          else                   p0_rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      win_q       <= PORT_CPU;
      last_q      <= PORT_AUX;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_gnt    = (state_q == ACCESS) && (win_q == PORT_CPU);
  assign p1_gnt    = (state_q == ACCESS) && (win_q == PORT_AUX);
  assign p0_done   = (state_q == RESP) && (win_q == PORT_CPU);
  assign p1_done   = (state_q == RESP) && (win_q == PORT_AUX);
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with random two-port traffic
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } item_t;

  item_t       q0[$], q1[$];
  item_t       mon_it;
  logic [15:0] ref_mem [256];
  logic [15:0] model_rd [2];
  int          n_chk = 0, n_fail = 0;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a ^ 8'h5A, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: read data appears MEM_LAT cycles after the strobe, garbage otherwise
  logic [15:0] mem [256];
  bit          mem_vld [256];
  logic [15:0] rd_pipe [4];
  always @(posedge clk) begin
    for (int i = 3; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && !mem_we)
      rd_pipe[0] <= mem_vld[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    else
      rd_pipe[0] <= 16'($urandom);
    if (mem_en && mem_we) begin
      mem[mem_addr[7:0]]     <= mem_wdata;
      mem_vld[mem_addr[7:0]] <= 1'b1;
    end
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Monitor: predicts grants from IDLE requests and checks every cycle
  int       cyc = 0, done_cyc = -1, idle_cyc = -1;
  bit       gnt_exp = 0, gnt_port = 0, done_port = 0, last_win = 1;
  int       gnt_cyc [2], dn_cyc [2];
  int       gnt_order[$];
  logic [1:0] mon_req;
  int       qsz;

  always @(negedge clk) begin
    if (!reset_n) begin
      q0.delete(); q1.delete();
      gnt_exp = 0; done_cyc = -1; idle_cyc = -1; last_win = 1;
    end else begin
      cyc++;
      if (gnt_exp) begin
        chk("gnt_vec", {p1_gnt, p0_gnt}, gnt_port ? 2'b10 : 2'b01);
        chk("busy_in_access", busy, 1'b1);
        qsz = gnt_port ? q1.size() : q0.size();
        chk("sb_item_at_gnt", qsz != 0, 1'b1);
        if (qsz != 0) begin
          mon_it = gnt_port ? q1[0] : q0[0];
          chk("mem_strobe", {mem_en, mem_we}, {1'b1, mon_it.wr});
          chk("mem_addr", mem_addr, mon_it.addr);
          if (mon_it.wr) chk("mem_wdata", mem_wdata, mon_it.wdata);
          done_port = gnt_port;
          done_cyc  = cyc + (mon_it.wr ? 1 : 1 + MEM_LAT);
        end
        gnt_cyc[gnt_port] = cyc;
        gnt_order.push_back(int'(gnt_port));
        gnt_exp = 0;
      end else begin
        chk("quiet_outside_access", {p1_gnt, p0_gnt, mem_en, mem_we, mem_addr, mem_wdata}, 36'h0);
      end
      if (cyc == done_cyc) begin
        chk("done_vec", {p1_done, p0_done}, done_port ? 2'b10 : 2'b01);
        if (done_port) begin
          mon_it = q1.pop_front();
          chk("p1_rdata", p1_rdata, mon_it.rdata);
        end else begin
          mon_it = q0.pop_front();
          chk("p0_rdata", p0_rdata, mon_it.rdata);
        end
        last_win = done_port;
        dn_cyc[done_port] = cyc;
        idle_cyc = cyc + 1;
        done_cyc = -1;
      end else begin
        chk("no_done", {p1_done, p0_done}, 2'b00);
      end
      if (cyc == idle_cyc) chk("idle_after_resp", busy, 1'b0);
      if (!busy) begin
        mon_req = {p1_read | p1_write, p0_read | p0_write};
        if (mon_req != 2'b00) begin
          gnt_exp  = 1;
          gnt_port = (mon_req == 2'b11) ? ~last_win : mon_req[1];
        end
      end
    end
  end

  function automatic void issue(input int port, input bit wr, input logic [15:0] a,
                                input logic [15:0] d);
    item_t it;
    it.wr = wr; it.addr = a; it.wdata = d;
    if (wr) begin
      ref_mem[a[7:0]] = d;
      it.rdata = model_rd[port];
    end else begin
      it.rdata = ref_mem[a[7:0]];
      model_rd[port] = it.rdata;
    end
    if (port == 1) q1.push_back(it);
    else           q0.push_back(it);
  endfunction

  task automatic drive(input int port, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit en);
    if (port == 1) begin
      p1_read = en & ~wr; p1_write = en & wr; p1_addr = a; p1_wdata = d;
    end else begin
      p0_read = en & ~wr; p0_write = en & wr; p0_addr = a; p0_wdata = d;
    end
  endtask

  task automatic do_req(input int port, input bit wr, input logic [15:0] a, input logic [15:0] d);
    bit seen;
    issue(port, wr, a, d);
    @(posedge clk); #1;
    drive(port, wr, a, d, 1'b1);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = (port == 1) ? p1_gnt : p0_gnt;
    end
    chk("gnt_wait", seen, 1'b1);
    @(posedge clk); #1;
    drive(port, 1'b0, 16'h0, 16'h0, 1'b0);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = (port == 1) ? p1_done : p0_done;
    end
    chk("done_wait", seen, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {p0_gnt, p0_done, p1_gnt, p1_done, mem_en, mem_we, busy}, 7'h0);
    chk({tag, "_rdata"}, {p0_rdata, p1_rdata}, 32'h0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    model_rd[0] = '0; model_rd[1] = '0;

    // Reset with random inputs
    reset_n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      p0_read = 1'($urandom); p0_write = 1'($urandom); p0_addr = 16'($urandom); p0_wdata = 16'($urandom);
      p1_read = 1'($urandom); p1_write = 1'($urandom); p1_addr = 16'($urandom); p1_wdata = 16'($urandom);
      @(negedge clk);
      check_all_zero("reset");
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
    reset_n = 1;
    @(negedge clk);
    chk("busy_after_release", busy, 1'b0);

    // Single read and single write
    do_req(0, 1'b0, 16'h0010, 16'h0);
    chk("single_read_rdata", p0_rdata, 16'hBEEF);
    do_req(1, 1'b1, 16'h0020, 16'h1234);
    chk("write_keeps_rdata", p1_rdata, model_rd[1]);

    // Contention: both ports re-request straight after each done
    gnt_order.delete();
    fork
      begin for (int i = 0; i < 2; i++) do_req(0, 1'b0, {9'h0, 7'(i * 5 + 1)}, 16'h0); end
      begin for (int j = 0; j < 2; j++) do_req(1, 1'b0, {9'h1, 7'(j * 3)}, 16'h0); end
    join
    chk("contention_count", gnt_order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_order.size()) chk("contention_order", gnt_order[i], i % 2);

    // Late arrival during a port 0 read
    fork
      do_req(0, 1'b0, 16'h0011, 16'h0);
      begin repeat (3) @(posedge clk); do_req(1, 1'b0, 16'h0085, 16'h0); end
    join
    chk("late_gnt_cycle", gnt_cyc[1], dn_cyc[0] + 2);

    // Reset in the middle of a read
    issue(0, 1'b0, 16'h0010, 16'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0010, 16'h0, 1'b1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = p0_gnt;
    end
    chk("rst_mid_gnt", seen, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    #2;
    reset_n = 0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    model_rd[0] = '0; model_rd[1] = '0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_no_done", {p1_done, p0_done, busy}, 3'b000);
    end
    do_req(0, 1'b0, 16'h0010, 16'h0);
    chk("after_rst_rdata", p0_rdata, 16'hBEEF);

    // Random traffic on disjoint address halves
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_req(0, 1'($urandom), {9'h0, 7'($urandom)}, 16'($urandom));
        end
      end
      begin
        for (int j = 0; j < 25; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          do_req(1, 1'($urandom), {9'h1, 7'($urandom)}, 16'($urandom));
        end
      end
    join

    repeat (5) @(negedge clk);
    chk("sb_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
